// File: rtl/start_bit_validator_pkg.sv
// start_bit_validator_pkg: shared state type, idle line level and legal parameter bounds
package uart_rx_pkg;
  typedef enum logic [1:0] {SB_IDLE, SB_CHECK, SB_HOLD} sb_state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 16;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  localparam int OS_MIN = 4;
  localparam int OS_MAX = 64;
endpackage

// File: rtl/start_bit_validator_if.sv
// start_bit_validator_if: pad-side inputs, re-arm handshake and per-channel status
// Ports: enable, tick (shared); serial_in, rearm, start_valid, false_start, busy (NUM_CH wide)
// master drives the inputs (downstream/test side), slave is the validator
interface start_bit_validator_if #(parameter int NUM_CH = 1);
  logic enable;
  logic tick;
  logic [NUM_CH-1:0] serial_in;
  logic [NUM_CH-1:0] rearm;
  logic [NUM_CH-1:0] start_valid;
  logic [NUM_CH-1:0] false_start;
  logic [NUM_CH-1:0] busy;
  modport master(output enable, tick, serial_in, rearm, input start_valid, false_start, busy);
  modport slave(input enable, tick, serial_in, rearm, output start_valid, false_start, busy);
endinterface

// File: rtl/start_bit_validator_ch.sv
// start_bit_ch: one channel - synchroniser, falling-edge detect, mid-bit check FSM
// Ports: clk, n_rst (async low), enable, tick, serial_in, rearm in; start_valid, false_start, busy out (registered)
// START_MAJ_FILTER_EN: decisions use a 2-of-3 majority of line over the last three clks
module start_bit_ch
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W = $clog2(OVERSAMPLE)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic tick,
  input  logic serial_in,
  input  logic rearm,
  output logic start_valid,
  output logic false_start,
  output logic busy
);
  localparam int HALF = OVERSAMPLE / 2;
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  logic line;
  logic fall;
  logic high;
  sb_state_t state;
  logic [CNT_W-1:0] cnt;
  assign line = sync[SYNC_STAGES-1];
  assign fall = hist & ~line;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync <= {SYNC_STAGES{LINE_IDLE}};
      hist <= LINE_IDLE;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], serial_in};
      hist <= line;
    end
  end
`ifdef START_MAJ_FILTER_EN
  // window = current line plus the two previous clk samples
  logic [1:0] win;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) win <= {2{LINE_IDLE}};
    else win <= {win[0], line};
  end
  assign high = (win[1] & win[0]) | (win[1] & line) | (win[0] & line);
`else
  assign high = line;
`endif
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= SB_IDLE;
      cnt <= '0;
      start_valid <= 1'b0;
      false_start <= 1'b0;
      busy <= 1'b0;
    end else begin
      start_valid <= 1'b0;
      false_start <= 1'b0;
      if (!enable) begin
        state <= SB_IDLE;
        cnt <= '0;
        busy <= 1'b0;
      end else begin
        case (state)
          SB_IDLE: if (fall) begin
            state <= SB_CHECK;
            cnt <= '0;
            busy <= 1'b1;
          end
          SB_CHECK: if (tick) begin
            if (high) begin
              false_start <= 1'b1;
              state <= SB_IDLE;
              busy <= 1'b0;
            end else if (cnt == CNT_W'(HALF - 1)) begin
              start_valid <= 1'b1;
              state <= SB_HOLD;
            end else cnt <= cnt + 1'b1;
          end
          SB_HOLD: if (rearm) begin
            state <= SB_IDLE;
            busy <= 1'b0;
          end
          default: begin
            state <= SB_IDLE;
            busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/start_bit_validator.sv
// start_bit_validator: NUM_CH independent UART start-bit validators sharing tick and enable
// Ports: clk, n_rst (async active-low), bus (start_bit_validator_if.slave)
// Optional macro START_MAJ_FILTER_EN enables the 2-of-3 majority decision filter
module start_bit_validator
  import uart_rx_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W = $clog2(OVERSAMPLE)
) (
  input logic clk,
  input logic n_rst,
  start_bit_validator_if.slave bus
);
  initial begin
    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) $fatal(1, "NUM_CH out of range");
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) $fatal(1, "SYNC_STAGES out of range");
    if (OVERSAMPLE < OS_MIN || OVERSAMPLE > OS_MAX || OVERSAMPLE % 2 != 0) $fatal(1, "OVERSAMPLE illegal");
  end
  always @(clk) assert (!$isunknown(clk)) else $warning("clk is X");
  always @(posedge clk) begin
    assert (!$isunknown(n_rst)) else $warning("n_rst is X");
    assert (!$isunknown(bus.tick)) else $warning("tick is X");
    assert (!$isunknown(bus.serial_in)) else $warning("serial_in is X");
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    start_bit_ch #(.SYNC_STAGES(SYNC_STAGES), .OVERSAMPLE(OVERSAMPLE), .CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .n_rst(n_rst),
      .enable(bus.enable),
      .tick(bus.tick),
      .serial_in(bus.serial_in[i]),
      .rearm(bus.rearm[i]),
      .start_valid(bus.start_valid[i]),
      .false_start(bus.false_start[i]),
      .busy(bus.busy[i])
    );
  end
endmodule

// File: tb/tb_start_bit_validator.sv
// tb_start_bit_validator: table vectors, directed corner sequences and random stimulus vs a reference model
module tb_start_bit_validator;
  localparam int NCH = 2;
  localparam int SYNC = 2;
  localparam int OS = 16;
  localparam int HALF = OS / 2;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;
  start_bit_validator_if #(.NUM_CH(NCH)) bus();
  start_bit_validator #(.NUM_CH(NCH), .SYNC_STAGES(SYNC), .OVERSAMPLE(OS)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rnd_tick = 0;
  bit samp[NCH][SYNC+1];
  bit win[NCH][2];
  bit m_busy[NCH];
  bit m_check[NCH];
  int m_ticks[NCH];
  logic [NCH-1:0] m_sv, m_fs, m_bz;
  int sv_cnt[NCH];
  int fs_cnt[NCH];
  typedef struct {
    int ch;
    int low_len;
    int exp_sv;
    int exp_fs;
  } vec_t;
  vec_t vt[6];
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k <= SYNC; k++) samp[c][k] = 1'b1;
      win[c][0] = 1'b1;
      win[c][1] = 1'b1;
      m_busy[c] = 0;
      m_check[c] = 0;
      m_ticks[c] = 0;
    end
    m_sv = '0;
    m_fs = '0;
    m_bz = '0;
  endfunction
  // samp[c][k] holds the pad value captured k+1 clks ago; the decision line lags the pad by SYNC clks
  function automatic void model_edge();
    for (int c = 0; c < NCH; c++) begin
      bit line, fall, high;
      line = samp[c][SYNC-1];
      fall = samp[c][SYNC] & ~line;
`ifdef START_MAJ_FILTER_EN
      high = (int'(win[c][0]) + int'(win[c][1]) + int'(line)) >= 2;
`else
      high = line;
`endif
      m_sv[c] = 1'b0;
      m_fs[c] = 1'b0;
      if (!bus.enable) begin
        m_busy[c] = 0;
        m_check[c] = 0;
      end else if (!m_busy[c]) begin
        if (fall) begin
          m_busy[c] = 1;
          m_check[c] = 1;
          m_ticks[c] = 0;
        end
      end else if (m_check[c]) begin
        if (bus.tick) begin
          if (high) begin
            m_fs[c] = 1'b1;
            m_busy[c] = 0;
            m_check[c] = 0;
          end else begin
            m_ticks[c]++;
            if (m_ticks[c] == HALF) begin
              m_sv[c] = 1'b1;
              m_check[c] = 0;
            end
          end
        end
      end else if (bus.rearm[c]) m_busy[c] = 0;
      m_bz[c] = m_busy[c];
      for (int k = SYNC; k > 0; k--) samp[c][k] = samp[c][k-1];
      samp[c][0] = bus.serial_in[c];
      win[c][1] = win[c][0];
      win[c][0] = line;
    end
  endfunction
  task automatic step();
    bus.tick = rnd_tick ? ($urandom_range(0, 2) == 0) : (cyc % 4 == 0);
    @(posedge clk);
    model_edge();
    #1;
    check("outputs", int'({bus.start_valid, bus.false_start, bus.busy}), int'({m_sv, m_fs, m_bz}));
    for (int c = 0; c < NCH; c++) begin
      sv_cnt[c] += int'(bus.start_valid[c]);
      fs_cnt[c] += int'(bus.false_start[c]);
    end
    cyc++;
  endtask
  task automatic clr_cnt();
    for (int c = 0; c < NCH; c++) begin
      sv_cnt[c] = 0;
      fs_cnt[c] = 0;
    end
  endtask
  task automatic align(input int ph);
    while (cyc % 4 != ph) step();
  endtask
  task automatic rearm_all();
    bus.rearm = '1;
    step();
    bus.rearm = '0;
    repeat (4) step();
  endtask
  initial begin
    int n;
    bit found;
    vt[0] = '{0, 100, 1, 0};
    vt[1] = '{1, 12, 0, 1};
    vt[2] = '{0, 1, 0, 1};
    vt[3] = '{1, 40, 1, 0};
    vt[4] = '{0, 3, 0, 1};
    vt[5] = '{1, 100, 1, 0};
    bus.enable = 1'b1;
    bus.tick = 1'b0;
    bus.serial_in = '1;
    bus.rearm = '0;
    model_reset();
    clr_cnt();
    #12;
    check("rst_sv", int'(bus.start_valid), 0);
    check("rst_fs", int'(bus.false_start), 0);
    check("rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (4) step();
    foreach (vt[v]) begin
      clr_cnt();
      bus.serial_in[vt[v].ch] = 1'b0;
      repeat (vt[v].low_len) step();
      bus.serial_in[vt[v].ch] = 1'b1;
      repeat (50) step();
      rearm_all();
      check($sformatf("vec%0d_sv", v), sv_cnt[vt[v].ch], vt[v].exp_sv);
      check($sformatf("vec%0d_fs", v), fs_cnt[vt[v].ch], vt[v].exp_fs);
      check($sformatf("vec%0d_other", v), sv_cnt[1-vt[v].ch] + fs_cnt[1-vt[v].ch], 0);
    end
    clr_cnt();
    align(0);
    bus.serial_in[0] = 1'b0;
    n = 0;
    found = 0;
    for (int i = 1; i <= 60 && !found; i++) begin
      step();
      if (i == 2) check("busy_before", int'(bus.busy[0]), 0);
      if (i == 3) check("busy_after3", int'(bus.busy[0]), 1);
      if (bus.start_valid[0]) begin
        found = 1;
        n = i;
      end
    end
    check("latency_ph0", n, 33);
    check("ch1_quiet", int'(bus.busy[1]), 0);
    repeat (3) step();
    bus.rearm[0] = 1'b1;
    step();
    bus.rearm[0] = 1'b0;
    check("rearm_idle", int'(bus.busy[0]), 0);
    repeat (40) step();
    check("no_retrigger", sv_cnt[0] + int'(bus.busy[0]), 1);
    bus.serial_in[0] = 1'b1;
    repeat (4) step();
    align(2);
    bus.serial_in[0] = 1'b0;
    n = 0;
    found = 0;
    for (int i = 1; i <= 60 && !found; i++) begin
      step();
      if (bus.start_valid[0]) begin
        found = 1;
        n = i;
      end
    end
    check("latency_ph2", n, 35);
    bus.serial_in[0] = 1'b1;
    rearm_all();
    bus.serial_in = '0;
    found = 0;
    for (int i = 1; i <= 60 && !found; i++) begin
      step();
      if (bus.start_valid != '0) begin
        found = 1;
        check("simul_sv", int'(bus.start_valid), 3);
      end
    end
    check("simul_seen", int'(found), 1);
    bus.serial_in = '1;
    rearm_all();
    clr_cnt();
    align(0);
    bus.serial_in[0] = 1'b0;
    repeat (21) step();
    check("abort_busy_pre", int'(bus.busy[0]), 1);
    bus.enable = 1'b0;
    step();
    check("abort_busy", int'(bus.busy[0]), 0);
    bus.enable = 1'b1;
    repeat (50) step();
    check("abort_pulses", sv_cnt[0] + fs_cnt[0], 0);
    bus.serial_in[0] = 1'b1;
    repeat (6) step();
    clr_cnt();
    bus.serial_in[1] = 1'b0;
    repeat (10) step();
    check("rst_mid_busy", int'(bus.busy[1]), 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_out", int'({bus.start_valid, bus.false_start, bus.busy}), 0);
    model_reset();
    bus.serial_in = '1;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (50) step();
    check("post_rst_pulses", sv_cnt[1] + fs_cnt[1], 0);
    clr_cnt();
    align(0);
    bus.serial_in[0] = 1'b0;
    repeat (14) step();
    bus.serial_in[0] = 1'b1;
    step();
    bus.serial_in[0] = 1'b0;
    repeat (6) step();
`ifdef START_MAJ_FILTER_EN
    check("glitch_fs", fs_cnt[0], 0);
`else
    check("glitch_fs", fs_cnt[0], 1);
`endif
    repeat (40) step();
    bus.serial_in[0] = 1'b1;
    rearm_all();
    rnd_tick = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 11) == 0) bus.serial_in[c] = ~bus.serial_in[c];
        bus.rearm[c] = ($urandom_range(0, 9) == 0);
      end
      bus.enable = ($urandom_range(0, 59) != 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
